vred_minmax_seq: RTL and testbench

Sequencer for vector min/max reductions (vredmin, vredminu, vredmax, vredmaxu) in the vALU. It accepts a stream of 64-bit beats of SEW-packed elements and folds each beat lanewise into an accumulator. After the last beat it tree-reduces the accumulator within the word, then combines the result with the scalar initial operand (vs1[0]). The single result element is returned on a valid/ready output port.

---
 rtl/vred_minmax_seq.sv | 186 ++++++++++++++++++
 tb/tb_vred_minmax_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vred_minmax_seq.sv
// Vector min/max reduction sequencer: folds 64-bit beats lanewise,
// tree-reduces within the word, then merges the scalar init element.
module vred_minmax_seq #(
   parameter int DATA_WIDTH = 64,
   parameter int SEW_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   input  logic [SEW_WIDTH-1:0]  in_sew,
   input  logic                  in_max,
   input  logic                  in_signed,
   input  logic [DATA_WIDTH-1:0] in_init,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy
);

   typedef enum logic [2:0] {
      IDLE, ACCUM, FOLD, SCALAR, OUT
   } state_t;

   state_t state, state_nx;

   logic [63:0] acc, init_q, res;
   logic [1:0]  sew_q, cnt;
   logic        max_q, sgn_q, vld_q;

   logic [2:0]  lvl;
   logic [63:0] hi, hmask, fold_v;

   function automatic logic take_b(
      input logic [64:0] ae,
      input logic [64:0] be,
      input logic        mx
   );
      if (mx) return $signed(be) > $signed(ae);
      return $signed(be) < $signed(ae);
   endfunction

   // Lanewise select; ties keep a.
   function automatic logic [63:0] vsel(
      input logic [63:0] a,
      input logic [63:0] b,
      input logic [1:0]  sew,
      input logic        mx,
      input logic        sg
   );
      logic [63:0] r;
      logic [64:0] ae, be;
      r  = a;
      ae = '0;
      be = '0;
      unique case (sew)
         2'd0: for (int i = 0; i < 8; i++) begin
            ae = {{57{sg & a[8*i+7]}}, a[8*i +: 8]};
            be = {{57{sg & b[8*i+7]}}, b[8*i +: 8]};
            if (take_b(ae, be, mx)) r[8*i +: 8] = b[8*i +: 8];
         end
         2'd1: for (int i = 0; i < 4; i++) begin
            ae = {{49{sg & a[16*i+15]}}, a[16*i +: 16]};
            be = {{49{sg & b[16*i+15]}}, b[16*i +: 16]};
            if (take_b(ae, be, mx)) r[16*i +: 16] = b[16*i +: 16];
         end
         2'd2: for (int i = 0; i < 2; i++) begin
            ae = {{33{sg & a[32*i+31]}}, a[32*i +: 32]};
            be = {{33{sg & b[32*i+31]}}, b[32*i +: 32]};
            if (take_b(ae, be, mx)) r[32*i +: 32] = b[32*i +: 32];
         end
         default: begin
            ae = {sg & a[63], a};
            be = {sg & b[63], b};
            if (take_b(ae, be, mx)) r = b;
         end
      endcase
      return r;
   endfunction

   function automatic logic [63:0] emask(input logic [1:0] sew);
      unique case (sew)
         2'd0:    return 64'h0000_0000_0000_00FF;
         2'd1:    return 64'h0000_0000_0000_FFFF;
         2'd2:    return 64'h0000_0000_FFFF_FFFF;
         default: return '1;
      endcase
   endfunction

   // sew+cnt identifies the active width: 3->64, 2->32, 1->16.
   assign lvl = {1'b0, sew_q} + {1'b0, cnt};

   always_comb begin
      hi    = '0;
      hmask = '0;
      unique case (lvl)
         3'd3: begin
            hi    = {32'b0, acc[63:32]};
            hmask = 64'h0000_0000_FFFF_FFFF;
         end
         3'd2: begin
            hi    = {48'b0, acc[31:16]};
            hmask = 64'h0000_0000_0000_FFFF;
         end
         default: begin
            hi    = {56'b0, acc[15:8]};
            hmask = 64'h0000_0000_0000_00FF;
         end
      endcase
      fold_v = vsel(acc, hi, sew_q, max_q, sgn_q) & hmask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b1;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               if (!in_last)         state_nx = ACCUM;
               else if (in_sew == 3) state_nx = SCALAR;
               else                  state_nx = FOLD;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && in_last)
               state_nx = (sew_q == 2'd3) ? SCALAR : FOLD;
         end
         FOLD:    if (cnt == 2'd1) state_nx = SCALAR;
         SCALAR:  state_nx = OUT;
         OUT:     if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         init_q <= '0;
         res    <= '0;
         sew_q  <= '0;
         cnt    <= '0;
         max_q  <= 1'b0;
         sgn_q  <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               acc    <= in_data;
               init_q <= in_init;
               sew_q  <= in_sew;
               max_q  <= in_max;
               sgn_q  <= in_signed;
               cnt    <= 2'd3 - in_sew;
            end
            ACCUM: if (in_valid)
               acc <= vsel(acc, in_data, sew_q, max_q, sgn_q);
            FOLD: begin
               acc <= fold_v;
               cnt <= cnt - 2'd1;
            end
            SCALAR: begin
               res <= vsel(init_q, acc, sew_q, max_q, sgn_q)
                      & emask(sew_q);
               vld_q <= 1'b1;
            end
            OUT: if (out_ready) vld_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign out_valid = vld_q;
   assign out_data  = res;

endmodule

// File: tb/tb_vred_minmax_seq.sv
// Scoreboard bench for vred_minmax_seq: directed reductions with
// hand-computed results, latency, backpressure and mid-fold reset.
module tb_vred_minmax_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic        in_last = 1'b0;
   logic [1:0]  in_sew = '0;
   logic        in_max = 1'b0;
   logic        in_signed = 1'b0;
   logic [63:0] in_init = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_data;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int pops  = 0;
   logic [63:0] exp_q[$];
   logic [63:0] bv[8];

   vred_minmax_seq #(.DATA_WIDTH(64), .SEW_WIDTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last),
      .in_sew(in_sew), .in_max(in_max),
      .in_signed(in_signed), .in_init(in_init),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_out: got %h want none",
                     out_data);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               fails++;
               $display("FAIL result: got %h want %h", out_data, e);
            end
         end
         pops++;
      end
   end

   task automatic send(input logic [63:0] d, input logic last,
                       input logic [1:0] sew, input logic mx,
                       input logic sg, input logic [63:0] init);
      int n;
      in_valid  = 1'b1;
      in_data   = d;
      in_last   = last;
      in_sew    = sew;
      in_max    = mx;
      in_signed = sg;
      in_init   = init;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("in_ready_timeout", 64'(n), 64'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_out(input int lat);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         check("busy_wait", 64'(busy), 64'd1);
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", 64'(n), 64'(lat));
   endtask

   task automatic reduce(input int nb, input logic [1:0] sew,
                         input logic mx, input logic sg,
                         input logic [63:0] init,
                         input logic [63:0] exp,
                         input bit gap, input bit hold);
      logic [63:0] held;
      int p0;
      exp_q.push_back(exp);
      out_ready = !hold;
      for (int k = 0; k < nb; k++) begin
         if (gap && (k % 2 == 1)) begin
            @(posedge clk);
            #1;
         end
         send(bv[k], k == nb - 1, sew, mx, sg, init);
      end
      wait_out(int'(3 - sew) + 1);
      if (hold) begin
         held = out_data;
         p0 = pops;
         for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", out_data, held);
            check("hold_in_ready", 64'(in_ready), 64'd0);
         end
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         check("hold_one_xfer", 64'(pops - p0), 64'd1);
      end else begin
         check("busy_out", 64'(busy), 64'd1);
         @(posedge clk);
         #1;
      end
      check("valid_clr", 64'(out_valid), 64'd0);
      check("busy_clr", 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      #2;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      bv[0] = 64'h0102_0304_0506_0708;
      reduce(1, 2'd0, 1'b0, 1'b0, 64'hFF, 64'h01, 0, 0);

      bv[0] = 64'h8000_7FFE_0001_FFFF;
      bv[1] = 64'h0002_7FFF_8001_0000;
      reduce(2, 2'd1, 1'b1, 1'b1, 64'h8000, 64'h7FFF, 0, 0);

      bv[0] = 64'hFFFF_FFFF_0000_0005;
      reduce(1, 2'd2, 1'b0, 1'b1, 64'h7, 64'hFFFF_FFFF, 0, 0);
      reduce(1, 2'd2, 1'b0, 1'b0, 64'h7, 64'h5, 0, 0);

      bv[0] = 64'h10;
      reduce(1, 2'd3, 1'b1, 1'b0, 64'h20, 64'h20, 0, 0);

      bv[0] = 64'h0000_0009_0000_0003;
      reduce(1, 2'd2, 1'b1, 1'b0, 64'h4, 64'h9, 0, 1);

      for (int k = 0; k < 8; k++) bv[k] = {8{8'h40}};
      bv[6] = 64'h4040_4040_4040_0740;
      reduce(8, 2'd0, 1'b0, 1'b0, 64'hFF, 64'h07, 1, 0);

      bv[0] = 64'h0102_0304_0506_0708;
      send(bv[0], 1'b1, 2'd0, 1'b1, 1'b0, 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_data", out_data, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("mid_rst_no_out", 64'(seen), 64'd0);
      @(posedge clk);
      #1;

      bv[0] = 64'h7F80_0102_0304_05FE;
      reduce(1, 2'd0, 1'b1, 1'b1, 64'h80, 64'h7F, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
